bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-add-3 / double dabble) that sits directly
//   upstream of the per-digit BCD-to-7-segment decoders on the DE10 HEX displays.
//   Accepts a binary word on a start strobe, iterates one bit per clock, then presents
//   DIGITS packed BCD nibbles plus a one-cycle done pulse; each nibble feeds one decoder.
// PARAMETERS
//   BIN_W   10  width of binary input, >= 1
//   DIGITS  4   number of BCD digits produced, >= 1
// PORTS
//   clk       in   1           system clock, rising edge
//   rst_n     in   1           asynchronous active-low reset
//   start     in   1           conversion request, sampled only in IDLE
//   bin       in   BIN_W       binary value, sampled on accepted start
//   busy      out  1           high while a conversion is in progress
//   done      out  1           one-cycle pulse when bcd/overflow update
//   bcd       out  4*DIGITS    packed digits, [3:0] = ones digit
//   overflow  out  1           last accepted bin >= 10**DIGITS
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, busy=0, done=0, overflow=0,
//     bcd=0, internal shift/scratch registers and bit counter = 0.
//   - States: IDLE -> SHIFT -> FINISH -> IDLE.
//     IDLE: start=1 -> latch bin into shift reg, clear scratch, cnt=BIN_W, busy=1, go SHIFT.
//     SHIFT: each cycle, every scratch nibble >= 5 gets +3 (all nibbles in parallel,
//       same cycle), then {scratch,shift} shifts left 1; cnt decrements; cnt reaching 0
//       -> FINISH. Scratch is DIGITS+1 nibbles wide internally so overflow is detectable.
//     FINISH: register bcd and overflow, done=1 for exactly this cycle, busy=0 next cycle,
//       go IDLE.
//   - Latency: start accepted at edge N -> done high in cycle N+BIN_W+1; busy high
//     cycles N+1 .. N+BIN_W+1 inclusive of the done cycle.
//   - start while busy is ignored (not queued). start in the cycle after done is
//     accepted normally; back-to-back throughput = one result per BIN_W+2 cycles.
//   - bin is only sampled on acceptance; changes during conversion have no effect.
//   - bcd and overflow hold their value between done pulses; never show partial results.
//   - Overflow: if value >= 10**DIGITS, overflow=1 and bcd saturates to all 4'h9.
//     Otherwise overflow=0 and bcd is the exact decimal value.
//   - Reset mid-conversion aborts immediately to reset values; no done is produced.
//   - bin=0 is a valid input: result bcd=0, done still pulses after full latency.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: in FINISH, every nibble above the highest nonzero
//     digit is replaced by 4'hF (downstream decoder renders 10-15 as all segments off).
//     The ones digit is never blanked, so value 0 yields {F..F,0}. Not applied when
//     overflow=1 (all 9s shown).
//   Undefined: leading zeros are output as 4'h0. Timing and handshake are identical.
// TESTING
//   1 Assert rst_n=0 mid-run -> busy=0, done=0, bcd=0, overflow=0 asynchronously.
//   2 Default params, start with bin=10'd0 at edge N -> done only in cycle N+11,
//     bcd=16'h0000 (16'hFFF0 with LEADING_ZERO_BLANK_EN), overflow=0.
//   3 bin=10'd1023 -> bcd=16'h1023; bin=10'd59 -> bcd=16'h0059
//     (16'hFF59 with macro); bin=10'd500 -> 16'h0500 / 16'hF500.
//   4 Start bin=37, pulse start with bin=999 at cycle N+4 -> single done, bcd=16'h0037;
//     then start on the cycle after done with bin=999 -> accepted, bcd=16'h0999.
//   5 DIGITS=3, BIN_W=10: bin=999 -> bcd=12'h999, overflow=0; bin=1000 ->
//     overflow=1, bcd=12'h999; bin=1023 -> overflow=1.
//   6 rst_n pulsed low at cycle N+5 of a conversion, released -> no done pulse, module
//     idle; a new start with bin=42 then completes normally with bcd=16'h0042.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-add-3 binary to packed BCD converter; LEADING_ZERO_BLANK_EN blanks leading zeros to 4'hF
module bin_to_bcd_seq #(
   parameter int BIN_W  = 10,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);
   localparam int SW = 4*(DIGITS+1);
   localparam int CW = $clog2(BIN_W+1);
   localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, FINISH = 2'd2;
   logic [1:0]          state;
   logic [BIN_W-1:0]    shreg;
   logic [SW-1:0]       scr, adj, scr_nx;
   logic [CW-1:0]       cnt;
   logic                ovf, ovf_nx;
   logic [4*DIGITS-1:0] fin;
   // add 3 to every scratch nibble >= 5, shift in the next binary bit; a nonzero top nibble means value >= 10**DIGITS and is kept sticky
   always_comb begin
      adj = scr;
      for (int i = 0; i < DIGITS+1; i++)
         if (scr[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
      scr_nx = {adj[SW-2:0], shreg[BIN_W-1]};
      ovf_nx = ovf | (scr_nx[SW-1 -: 4] != 4'h0);
   end
`ifdef LEADING_ZERO_BLANK_EN
   logic lead;
   // replace zero digits above the highest nonzero digit with 4'hF; the ones digit always shows
   always_comb begin
      fin  = scr_nx[4*DIGITS-1:0];
      lead = 1'b1;
      for (int i = DIGITS-1; i > 0; i--) begin
         lead = lead & (fin[4*i +: 4] == 4'h0);
         if (lead) fin[4*i +: 4] = 4'hF;
      end
   end
`else
   // leading zeros are shown as 4'h0
   always_comb fin = scr_nx[4*DIGITS-1:0];
`endif
   // control FSM and datapath; result and done are registered together so bcd is valid while done is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         shreg    <= '0;
         scr      <= '0;
         cnt      <= '0;
         ovf      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && start) begin
            shreg <= bin;
            scr   <= '0;
            cnt   <= CW'(BIN_W);
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= SHIFT;
         end else if (state == SHIFT) begin
            shreg <= shreg << 1;
            scr   <= scr_nx;
            ovf   <= ovf_nx;
            cnt   <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
               state    <= FINISH;
               done     <= 1'b1;
               overflow <= ovf_nx;
               bcd      <= ovf_nx ? {DIGITS{4'h9}} : fin;
            end
         end else if (state == FINISH) begin
            busy  <= 1'b0;
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed checks of bin_to_bcd_seq with DIGITS=4 and DIGITS=3 instances driven in parallel
module tb_bin_to_bcd_seq;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  bin = '0;
   logic        busy4, done4, ovf4, busy3, done3, ovf3;
   logic [15:0] bcd4;
   logic [11:0] bcd3;
   int          nvec = 0;
   int          nerr = 0;

   bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
      .busy(busy4), .done(done4), .bcd(bcd4), .overflow(ovf4));
   bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
      .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one conversion; imm starts in the current cycle, poke_at pulses start again mid-conversion (0 = none)
   task automatic convert(input bit imm, input logic [9:0] b, input int poke_at, input logic [9:0] poke,
                          input logic [15:0] e4, input logic o4, input logic [11:0] e3, input logic o3);
      int lat;
      if (!imm) @(negedge clk);
      start = 1'b1;
      bin   = b;
      lat   = 0;
      do begin
         @(negedge clk);
         lat++;
         start = (lat == poke_at);
         bin   = (lat == poke_at) ? poke : ~b;
      end while (!done4 && lat < 40);
      check("latency", lat, 11);
      check("busy_at_done", busy4, 1);
      check("bcd4", bcd4, e4);
      check("ovf4", ovf4, o4);
      check("done3", done3, 1);
      check("bcd3", bcd3, e3);
      check("ovf3", ovf3, o3);
      @(negedge clk);
      start = 1'b0;
      check("done_width", done4, 0);
      check("busy_after", busy4, 0);
      check("bcd4_hold", bcd4, e4);
   endtask

   initial begin
      int seen;
      #1 rst_n = 1'b0;
      #2;
      check("rst_busy", busy4, 0);
      check("rst_done", done4, 0);
      check("rst_bcd", bcd4, 0);
      check("rst_ovf", ovf4, 0);
      @(negedge clk);
      rst_n = 1'b1;
      convert(0, 10'd0,    0, 0, BLANK ? 16'hFFF0 : 16'h0000, 0, BLANK ? 12'hFF0 : 12'h000, 0);
      convert(0, 10'd1023, 0, 0, 16'h1023, 0, 12'h999, 1);
      convert(0, 10'd59,   0, 0, BLANK ? 16'hFF59 : 16'h0059, 0, BLANK ? 12'hF59 : 12'h059, 0);
      convert(0, 10'd500,  0, 0, BLANK ? 16'hF500 : 16'h0500, 0, 12'h500, 0);
      convert(0, 10'd1000, 0, 0, 16'h1000, 0, 12'h999, 1);
      convert(0, 10'd37,   4, 10'd999, BLANK ? 16'hFF37 : 16'h0037, 0, BLANK ? 12'hF37 : 12'h037, 0);
      convert(1, 10'd999,  0, 0, BLANK ? 16'hF999 : 16'h0999, 0, 12'h999, 0);
      @(negedge clk);
      start = 1'b1;
      bin   = 10'd300;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy4, 0);
      check("abort_done", done4, 0);
      check("abort_bcd", bcd4, 0);
      check("abort_ovf", ovf4, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done4) seen++;
      end
      check("abort_no_done", seen, 0);
      check("abort_idle", busy4, 0);
      convert(0, 10'd42, 0, 0, BLANK ? 16'hFF42 : 16'h0042, 0, BLANK ? 12'hF42 : 12'h042, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
